uart_tx_arbiter: RTL

- Shares one 8N1 serial transmit line among NUM_REQ requesters on the 50 MHz board clock.
- Round-robin arbitration, byte capture with a one-cycle Ack handshake, and bit-period sequencing of start, data and stop bits.
- Sits between on-chip byte producers (status reporters, echo path of the serial receiver) and the board TX pin.
- Companion to the serial receive path: same bit timing, same reset scheme.

---
 rtl/uart_tx_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 serial transmit line among NUM_REQ byte producers.
// Optional even parity bit between data and stop: define UART_TX_ARB_PARITY_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BIT_CYCLES = 5208,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [8*NUM_REQ-1:0] DataIn,
  output logic [NUM_REQ-1:0]   Ack,
  output logic [NUM_REQ-1:0]   Grant,
  output logic                 SerialOut,
  output logic                 Busy,
  output logic                 FrameDone
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

`ifdef UART_TX_ARB_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} stateType;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} stateType;
`endif

  stateType            stateQ, stateD;
  logic [PtrW-1:0]     ptrQ, ptrD;
  logic [PtrW-1:0]     pick, cand;
  logic                pickValid;
  logic [7:0]          pickByte;
  logic [NUM_REQ-1:0]  pickOneHot;
  logic [7:0]          shiftQ, shiftD;
  logic [2:0]          bitIdxQ, bitIdxD;
  logic [CntW-1:0]     cycleQ, cycleD;
  logic                stopIdxQ, stopIdxD;
  logic [NUM_REQ-1:0]  ackD, grantD;
  logic                serialD, busyD, frameDoneD;
  logic                bitWrap, lastStop;
`ifdef UART_TX_ARB_PARITY_EN
  logic                parityQ, parityD;
`endif

  assign bitWrap  = (cycleQ == CntW'(BIT_CYCLES - 1));
  assign lastStop = (stopIdxQ == 1'(STOP_BITS - 1));

  // Round-robin search: first requester with Req set, starting just above the last owner.
  always_comb begin
    pick      = '0;
    cand      = '0;
    pickValid = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = PtrW'((32'(ptrQ) + off) % NUM_REQ);
      if (!pickValid && Req[cand]) begin
        pick      = cand;
        pickValid = 1'b1;
      end
    end
  end

  // Byte and one-hot of the winning requester.
  always_comb begin
    pickByte   = '0;
    pickOneHot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick == PtrW'(i)) begin
        pickByte      = DataIn[8*i +: 8];
        pickOneHot[i] = 1'b1;
      end
    end
  end

  // State and output registers; reset drives the line idle-high and drops any frame.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateQ    <= StIdle;
      ptrQ      <= PtrW'(NUM_REQ - 1);
      shiftQ    <= '0;
      bitIdxQ   <= '0;
      cycleQ    <= '0;
      stopIdxQ  <= 1'b0;
      Ack       <= '0;
      Grant     <= '0;
      SerialOut <= 1'b1;
      Busy      <= 1'b0;
      FrameDone <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
      parityQ   <= 1'b0;
`endif
    end else begin
      stateQ    <= stateD;
      ptrQ      <= ptrD;
      shiftQ    <= shiftD;
      bitIdxQ   <= bitIdxD;
      cycleQ    <= cycleD;
      stopIdxQ  <= stopIdxD;
      Ack       <= ackD;
      Grant     <= grantD;
      SerialOut <= serialD;
      Busy      <= busyD;
      FrameDone <= frameDoneD;
`ifdef UART_TX_ARB_PARITY_EN
      parityQ   <= parityD;
`endif
    end
  end

  // Next-state logic: every non-idle state advances only on a bit-period wrap.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (pickValid) stateD = StStart;
      StStart: if (bitWrap) stateD = StData;
      StData: begin
        if (bitWrap && bitIdxQ == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
          stateD = StParity;
`else
          stateD = StStop;
`endif
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      StParity: if (bitWrap) stateD = StStop;
`endif
      StStop:  if (bitWrap && lastStop) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Next values of datapath and registered outputs.
  always_comb begin
    ptrD       = ptrQ;
    shiftD     = shiftQ;
    bitIdxD    = bitIdxQ;
    stopIdxD   = stopIdxQ;
    cycleD     = (stateQ == StIdle || bitWrap) ? '0 : cycleQ + 1'b1;
    ackD       = '0;
    grantD     = Grant;
    serialD    = SerialOut;
    busyD      = Busy;
    frameDoneD = 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
    parityD    = parityQ;
`endif
    unique case (stateQ)
      StIdle: begin
        if (pickValid) begin
          shiftD  = pickByte;
          ackD    = pickOneHot;
          grantD  = pickOneHot;
          ptrD    = pick;
          serialD = 1'b0;
          busyD   = 1'b1;
          cycleD  = '0;
`ifdef UART_TX_ARB_PARITY_EN
          parityD = ^pickByte;
`endif
        end
      end
      StStart: begin
        if (bitWrap) begin
          serialD = shiftQ[0];
          shiftD  = shiftQ >> 1;
          bitIdxD = '0;
        end
      end
      StData: begin
        if (bitWrap) begin
          if (bitIdxQ == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
            serialD  = parityQ;
`else
            serialD  = 1'b1;
`endif
            stopIdxD = 1'b0;
          end else begin
            serialD = shiftQ[0];
            shiftD  = shiftQ >> 1;
            bitIdxD = bitIdxQ + 3'd1;
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      StParity: begin
        if (bitWrap) begin
          serialD  = 1'b1;
          stopIdxD = 1'b0;
        end
      end
`endif
      StStop: begin
        if (bitWrap) begin
          if (lastStop) begin
            frameDoneD = 1'b1;
            grantD     = '0;
            busyD      = 1'b0;
          end else begin
            stopIdxD = stopIdxQ + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
